// File: rtl/conv_stream_feeder.sv
// Initiator side of the convolution vector handshake: builds a stride-1 sliding
// window over a sample stream and runs one {kernel, window} transaction at a time.
module conv_stream_feeder #(
    parameter int LEN   = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LEN-1:0][WIDTH-1:0]  kernel_in,
    input  logic                       kernel_load,
    output logic                       kernel_ready,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           sample_in,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic [LEN-1:0][WIDTH-1:0]  conv_kernel,
    output logic [LEN-1:0][WIDTH-1:0]  conv_data,
    output logic                       conv_valid,
    input  logic                       conv_ready,
    input  logic [2*WIDTH-1:0]         conv_result,
    input  logic                       conv_out_valid,
    output logic                       conv_out_ready,
    output logic [2*WIDTH-1:0]         y,
    output logic                       y_valid,
    input  logic                       y_ready
);
    localparam int CW = $clog2(LEN + 1);

    typedef enum logic [1:0] {FILL, ISSUE, WAIT, EMIT} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [LEN-1:0][WIDTH-1:0]  win_q, ker_q;
    logic                       in_fill, accept;

    assign in_fill = (state_q == FILL);
    assign accept  = in_fill && sample_valid;

    // Flush takes effect first so a same-cycle sample still counts as one.
    always_comb begin
        cnt_d = cnt_q;
        if (in_fill && flush)
            cnt_d = '0;
        if (accept && cnt_d != CW'(LEN))
            cnt_d = cnt_d + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept && cnt_d == CW'(LEN)) state_d = ISSUE;
            ISSUE:   if (conv_ready)                  state_d = WAIT;
            WAIT:    if (conv_out_valid)              state_d = EMIT;
            EMIT:    if (y_ready)                     state_d = FILL;
            default:                                  state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Element 0 is the oldest sample; new samples enter at LEN-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            win_q <= '0;
        else if (accept)
            win_q <= {sample_in, win_q[LEN-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ker_q <= '0;
        else if (in_fill && kernel_load)
            ker_q <= kernel_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            y <= '0;
        else if (state_q == WAIT && conv_out_valid)
            y <= conv_result;
    end

    // Operands come straight from registers that only change in FILL, so they
    // hold steady for the whole operator transaction.
    assign conv_kernel    = ker_q;
    assign conv_data      = win_q;
    assign sample_ready   = in_fill;
    assign kernel_ready   = in_fill;
    assign conv_valid     = (state_q == ISSUE);
    assign conv_out_ready = (state_q == WAIT);
    assign y_valid        = (state_q == EMIT);

endmodule
